// File: rtl/div64x32_if.sv
// ----------------------------------------------------------------------------
// div64x32_if
// Request/response bundle for the 64/32 unsigned divider.
//   start        : request a division (master -> slave)
//   a [63:0]     : unsigned dividend (master -> slave)
//   b [31:0]     : unsigned divisor (master -> slave)
//   busy         : division in progress (slave -> master)
//   done         : one-cycle pulse, results valid (slave -> master)
//   q [31:0]     : quotient (slave -> master)
//   r [31:0]     : remainder (slave -> master)
//   div_by_zero  : divisor was zero (slave -> master)
//   overflow     : quotient does not fit in 32 bits (slave -> master)
// ----------------------------------------------------------------------------
interface div64x32_if;
   logic        start;
   logic [63:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] q;
   logic [31:0] r;
   logic        div_by_zero;
   logic        overflow;

   modport master (
      output start, a, b,
      input  busy, done, q, r, div_by_zero, overflow
   );

   modport slave (
      input  start, a, b,
      output busy, done, q, r, div_by_zero, overflow
   );
endinterface

// File: rtl/div64x32.sv
// ----------------------------------------------------------------------------
// div64x32
// Multi-cycle unsigned 64-bit by 32-bit restoring divider.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high reset
//   bus   : div64x32_if.slave -- start/a/b request, busy/done/q/r/flags result
// A request is accepted in IDLE, screened for divide-by-zero and quotient
// overflow in CHECK, then resolved one quotient bit per cycle over 32 CALC
// cycles. Results and flags hold until the next accepted start or reset.
// ----------------------------------------------------------------------------
module div64x32 (
   input logic       clk,
   input logic       reset,
   div64x32_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CHECK, CALC} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic        busy_r;
   logic        done_r;
   logic [31:0] q_r;
   logic [31:0] r_r;
   logic        dbz_r;
   logic        ovf_r;

   // Datapath registers (not reset: only meaningful once a request is taken)
   logic [31:0] b_p0;
   logic [32:0] rem_p0;      // partial remainder, starts as a[63:32]
   logic [31:0] dvd_lo_p0;   // low dividend half, shifted out MSB-first
   logic [31:0] quo_p0;      // quotient bits shifted in LSB-first

   logic [32:0] trial;
   logic        take;
   logic [32:0] step_rem;

   // One restoring step; the trial value is kept at full 33 bits so the
   // compare against b never loses the bit shifted out of the remainder.
   always_comb begin
      trial    = {rem_p0[31:0], dvd_lo_p0[31]};
      take     = (trial >= {1'b0, b_p0});
      step_rem = take ? (trial - {1'b0, b_p0}) : trial;
   end

   // Control FSM and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         q_r    <= '0;
         r_r    <= '0;
         dbz_r  <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  dbz_r  <= 1'b0;
                  ovf_r  <= 1'b0;
                  busy_r <= 1'b1;
                  state  <= CHECK;
               end
            end
            CHECK: begin
               if (b_p0 == 32'd0) begin
                  dbz_r  <= 1'b1;
                  q_r    <= 32'hFFFF_FFFF;
                  r_r    <= dvd_lo_p0;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end else if (rem_p0[31:0] >= b_p0) begin
                  ovf_r  <= 1'b1;
                  q_r    <= 32'hFFFF_FFFF;
                  r_r    <= 32'hFFFF_FFFF;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end else begin
                  cnt   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  q_r    <= {quo_p0[30:0], take};
                  r_r    <= step_rem[31:0];
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath: capture operands on acceptance, then one shift/subtract per CALC cycle
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (bus.start) begin
               b_p0      <= bus.b;
               rem_p0    <= {1'b0, bus.a[63:32]};
               dvd_lo_p0 <= bus.a[31:0];
            end
         end
         CALC: begin
            rem_p0    <= step_rem;
            dvd_lo_p0 <= {dvd_lo_p0[30:0], 1'b0};
            quo_p0    <= {quo_p0[30:0], take};
         end
         default: ;
      endcase
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.q           = q_r;
   assign bus.r           = r_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_div64x32.sv
// ----------------------------------------------------------------------------
// tb_div64x32
// Scoreboard bench for div64x32: the stimulus process pushes the expected
// result and the cycle it must appear in; a monitor pops and compares on
// every done pulse.
// ----------------------------------------------------------------------------
module tb_div64x32;

   logic clk;
   logic reset;
   int   cyc;
   int   tests;
   int   failed;

   div64x32_if bus ();

   div64x32 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      logic        ovf;
      int          at_cyc;
   } exp_t;

   exp_t sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL unexpected_done: got done=1, expected no pending result (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("q",           {32'd0, bus.q}, {32'd0, e.q});
               check("r",           {32'd0, bus.r}, {32'd0, e.r});
               check("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
               check("overflow",    {63'd0, bus.overflow}, {63'd0, e.ovf});
               check("done_cycle",  64'(cyc), 64'(e.at_cyc));
               check("busy_at_done", {63'd0, bus.busy}, 64'd0);
            end
         end
      end
   end

   task automatic wait_idle();
      int k;
      k = 0;
      while ((bus.busy !== 1'b0 || sb.size() != 0) && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) begin
         tests++;
         failed++;
         $display("FAIL wait_idle_timeout: got busy=%b pending=%0d, expected idle", bus.busy, sb.size());
         sb.delete();
      end
   endtask

   task automatic issue(input logic [63:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input logic eovf, input int lat);
      exp_t e;
      wait_idle();
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf; e.at_cyc = cyc + lat;
      sb.push_back(e);
      bus.start = 1'b0;
      bus.a     = {$urandom, $urandom};
      bus.b     = $urandom;
      @(negedge clk);
      check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      exp_t e;
      cyc       = 0;
      tests     = 0;
      failed    = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      check("rst_q",    {32'd0, bus.q}, 64'd0);
      check("rst_r",    {32'd0, bus.r}, 64'd0);
      check("rst_dbz",  {63'd0, bus.div_by_zero}, 64'd0);
      check("rst_ovf",  {63'd0, bus.overflow}, 64'd0);

      // Directed vectors
      issue(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33);
      issue(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 33);
      issue(64'h0000_0000_1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1);
      issue(64'h0000_0005_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
      issue(64'h0000_0004_FFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd4, 1'b0, 1'b0, 33);
      issue(64'h0000_0001_0000_0000, 32'd2, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 33);
      issue(64'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 33);
      wait_idle();

      // Reset in the middle of CALC: no done pulse, everything cleared
      bus.a     = 64'h0000_0000_DEAD_BEEF;
      bus.b     = 32'd3;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_busy", {63'd0, bus.busy}, 64'd0);
      check("midrst_done", {63'd0, bus.done}, 64'd0);
      check("midrst_q",    {32'd0, bus.q}, 64'd0);
      check("midrst_r",    {32'd0, bus.r}, 64'd0);
      check("midrst_dbz",  {63'd0, bus.div_by_zero}, 64'd0);
      check("midrst_ovf",  {63'd0, bus.overflow}, 64'd0);
      repeat (40) @(negedge clk);
      issue(64'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0, 33);
      wait_idle();

      // Handshake: re-pulse while busy is ignored; start held into done cycle
      bus.a     = 64'd100;
      bus.b     = 32'd7;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      n = cyc;
      e.q = 32'd14; e.r = 32'd2; e.dbz = 1'b0; e.ovf = 1'b0; e.at_cyc = n + 33;
      sb.push_back(e);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      bus.a     = 64'd50;
      bus.b     = 32'd3;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      bus.a     = 64'd9;
      bus.b     = 32'd4;
      bus.start = 1'b1;
      e.q = 32'd2; e.r = 32'd1; e.dbz = 1'b0; e.ovf = 1'b0; e.at_cyc = n + 67;
      sb.push_back(e);
      while (cyc < n + 34) @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check("b2b_busy_second", {63'd0, bus.busy}, 64'd1);
      wait_idle();

      repeat (3) @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/div64x32.md
DIV64X32 -- requirements
Module: div64x32

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled on a rising edge only while the block is idle.
REQ-005 a  input  64  unsigned dividend; sampled on the accepting edge only.
REQ-006 b  input  32  unsigned divisor; sampled on the accepting edge only.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; results valid in that cycle.
REQ-009 q  output  32  quotient register.
REQ-010 r  output  32  remainder register.
REQ-011 div_by_zero  output  1  error flag; divisor was 0.
REQ-012 overflow  output  1  error flag; quotient does not fit in 32 bits.

Function
REQ-013 The state machine SHALL have three states: IDLE, CHECK and CALC.
REQ-014 In IDLE, start=1 on edge N SHALL latch a and b into internal registers, clear done, div_by_zero and overflow, and go to CHECK.
REQ-015 While idle, start=0 SHALL leave state and all outputs unchanged.
REQ-016 busy SHALL be 1 exactly in CHECK and CALC, and 0 in IDLE.
REQ-017 busy SHALL be a registered output with no combinational path from start.
REQ-018 From CHECK, if b==0: next state IDLE, div_by_zero=1, q=32'hFFFF_FFFF, r=a[31:0], done=1 for one cycle.
REQ-019 From CHECK, else if a[63:32] >= b: next state IDLE, overflow=1, q=32'hFFFF_FFFF, r=32'hFFFF_FFFF, done=1 for one cycle.
REQ-020 From CHECK, otherwise: partial remainder = a[63:32], iteration counter = 0, next state CALC.
REQ-021 Each CALC cycle SHALL do one restoring step, consuming dividend bits MSB-first from a[31] down to a[0]:
- form the 33-bit value {rem, next dividend bit};
- if it is >= b, store (value - b) and shift quotient bit 1 in;
- else store the value unchanged and shift quotient bit 0 in.
REQ-022 CALC SHALL last exactly 32 cycles, counter 0..31.
REQ-023 On the edge completing iteration 31, q and r SHALL be loaded, done=1 for the following cycle, and the next state SHALL be IDLE.
REQ-024 Normal latency SHALL be: start accepted at edge N; results valid, busy=0 and done=1 after edge N+33 (busy high for 33 cycles).
REQ-025 Error latency SHALL be: results valid, busy=0 and done=1 after edge N+1.
REQ-026 q, r and the error flags SHALL hold their values until the next accepted start or reset.
REQ-027 q and r SHALL not change during CHECK or CALC.
REQ-028 start while busy=1 SHALL be ignored, and a and b changing while busy SHALL have no effect.
REQ-029 start=1 in the done cycle SHALL be accepted, giving back-to-back operation.
REQ-030 start held high continuously SHALL start a new division on each return to IDLE.
REQ-031 A normal result SHALL satisfy a == q*b + r with r < b.
REQ-032 The remainder datapath SHALL be 33 bits wide internally, with no truncation before the comparison.

Reset
REQ-033 With reset=1 at a rising edge, the block SHALL go to IDLE, clear the counter and set busy=0, done=0, q=0, r=0, div_by_zero=0, overflow=0.
REQ-034 Reset SHALL take priority over start and abort any operation in CHECK or CALC with no done pulse.
REQ-035 After reset is released, the first start SHALL behave as in REQ-014.

Verification
REQ-036 Basic: a=100, b=7, start pulse at edge N -> busy=1 for 33 cycles; after edge N+33: q=14, r=2, done=1 for one cycle, flags 0.
REQ-037 Maximum: a=64'hFFFF_FFFE_0000_0001, b=32'hFFFF_FFFF -> q=32'hFFFF_FFFF, r=0, overflow=0.
REQ-038 Divide by zero: a=64'h0000_0000_1234_5678, b=0 -> after edge N+1: div_by_zero=1, q=32'hFFFF_FFFF, r=32'h1234_5678, busy=0, done=1.
REQ-039 Overflow: a=64'h0000_0005_0000_0000, b=5 -> after edge N+1: overflow=1, q=r=32'hFFFF_FFFF, done=1.
REQ-040 Reset mid-CALC (iteration 10) -> next cycle: busy=0, q=r=0, flags 0, no done pulse; then a=1000, b=10 -> q=100, r=0.
REQ-041 Handshake: start re-pulsed while busy with different operands -> ignored, result unchanged; start held high in the done cycle with a=9, b=4 -> second result q=2, r=1 after a further 34 edges.
